// File: rtl/btb_pkg.sv
// Shared types and constants for the branch target buffer: 2-bit direction counter
// encoding, the target-table entry layout and the saturating counter update.
package btb_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;
  localparam logic [1:0] CNT_RST = CNT_WNT;

  // Fields are sized for the widest supported PC; narrower instances zero-extend and
  // the constant upper bits are trimmed by synthesis.
  localparam int unsigned BTB_MAX_W = 64;

  typedef struct packed {
    logic                 valid;
    logic [BTB_MAX_W-1:0] tag;
    logic [BTB_MAX_W-1:0] target;
  } btb_entry_t;

  function automatic logic [1:0] cnt_sat_update(logic [1:0] cnt, logic taken);
    if (taken) begin
      return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    end
    return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch-lookup and resolution-update bundle between the pipeline and the branch target
// buffer. The master modport is the pipeline side, the slave modport the predictor side.
interface branch_target_buffer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned GHR_W  = 4,
  parameter int unsigned STAT_W = 16
);

  logic              flush_i;
  logic [ADDR_W-1:0] lookup_pc_i;
  logic              pred_hit_o;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] pred_target_o;
  logic [GHR_W-1:0]  pred_ghr_o;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_pred_taken_i;
  logic [ADDR_W-1:0] upd_pred_target_i;
  logic [GHR_W-1:0]  upd_ghr_i;
  logic              mispredict_o;
  logic [STAT_W-1:0] stat_branch_o;
  logic [STAT_W-1:0] stat_mispred_o;

  modport master (
    output flush_i, lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_target_i, upd_ghr_i,
    input  pred_hit_o, pred_taken_o, pred_target_o, pred_ghr_o, mispredict_o,
           stat_branch_o, stat_mispred_o
  );

  modport slave (
    input  flush_i, lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_target_i, upd_ghr_i,
    output pred_hit_o, pred_taken_o, pred_target_o, pred_ghr_o, mispredict_o,
           stat_branch_o, stat_mispred_o
  );

endinterface

// File: rtl/btb_pht.sv
// Pattern table: ENTRIES 2-bit saturating direction counters with one combinational
// read port (returns the direction bit) and one trained write port.
module btb_pht
  import btb_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  logic [1:0] cnt_q [ENTRIES];

  assign rd_taken_o = cnt_q[rd_idx_i][1];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= CNT_RST;
      end
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= cnt_sat_update(cnt_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Tagged branch target buffer with 2-bit direction counters and saturating statistics.
// Define BTB_GSHARE_EN to hash the pattern-table index with a global history register.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned GHR_W   = 4,
  parameter int unsigned STAT_W  = 16
) (
  input logic                   clk_i,
  input logic                   rst_n,
  branch_target_buffer_if.slave btb
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  logic [IDX_W-1:0] lk_idx, upd_idx, lk_phi, upd_phi;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  btb_entry_t       tt_q [ENTRIES];
  btb_entry_t       lk_entry;
  logic             lk_cnt_taken;
  logic             mispredict;
  logic [STAT_W-1:0] stat_branch_q, stat_mispred_q;

  assign lk_idx  = btb.lookup_pc_i[IDX_W+1:2];
  assign lk_tag  = btb.lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign upd_idx = btb.upd_pc_i[IDX_W+1:2];
  assign upd_tag = btb.upd_pc_i[ADDR_W-1:IDX_W+2];

  logic unused_upd_pc_lo;
  assign unused_upd_pc_lo = ^btb.upd_pc_i[1:0];

`ifdef BTB_GSHARE_EN
  logic [GHR_W-1:0] ghr_q;

  // History is trained at resolution only, so wrong-path fetches never pollute it.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (btb.upd_valid_i) begin
      ghr_q <= GHR_W'({ghr_q, btb.upd_taken_i});
    end
  end

  assign lk_phi         = lk_idx ^ IDX_W'(ghr_q);
  assign upd_phi        = upd_idx ^ IDX_W'(btb.upd_ghr_i);
  assign btb.pred_ghr_o = ghr_q;
`else
  logic unused_upd_ghr;
  assign unused_upd_ghr = ^btb.upd_ghr_i;
  assign lk_phi         = lk_idx;
  assign upd_phi        = upd_idx;
  assign btb.pred_ghr_o = '0;
`endif

  btb_pht #(
    .ENTRIES (ENTRIES)
  ) u_pht (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .rd_idx_i   (lk_phi),
    .rd_taken_o (lk_cnt_taken),
    .wr_en_i    (btb.upd_valid_i),
    .wr_idx_i   (upd_phi),
    .wr_taken_i (btb.upd_taken_i)
  );

  assign lk_entry          = tt_q[lk_idx];
  assign btb.pred_hit_o    = lk_entry.valid && (lk_entry.tag == BTB_MAX_W'(lk_tag));
  assign btb.pred_taken_o  = btb.pred_hit_o && lk_cnt_taken;
  assign btb.pred_target_o = btb.pred_taken_o ? lk_entry.target[ADDR_W-1:0]
                                              : btb.lookup_pc_i + ADDR_W'(4);

  if (ADDR_W < BTB_MAX_W) begin : g_tgt_hi
    logic unused_tgt_hi;
    assign unused_tgt_hi = ^lk_entry.target[BTB_MAX_W-1:ADDR_W];
  end

  // Flush has priority over allocation; not-taken resolutions leave the entry alone.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tt_q[i] <= '0;
      end
    end else if (btb.flush_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tt_q[i].valid <= 1'b0;
      end
    end else if (btb.upd_valid_i && btb.upd_taken_i) begin
      tt_q[upd_idx] <= '{valid:  1'b1,
                         tag:    BTB_MAX_W'(upd_tag),
                         target: BTB_MAX_W'(btb.upd_target_i)};
    end
  end

  assign mispredict = btb.upd_valid_i &&
                      ((btb.upd_taken_i != btb.upd_pred_taken_i) ||
                       (btb.upd_taken_i && (btb.upd_target_i != btb.upd_pred_target_i)));
  assign btb.mispredict_o = mispredict;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stat_branch_q  <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (btb.upd_valid_i && (stat_branch_q != '1)) begin
        stat_branch_q <= stat_branch_q + STAT_W'(1);
      end
      if (mispredict && (stat_mispred_q != '1)) begin
        stat_mispred_q <= stat_mispred_q + STAT_W'(1);
      end
    end
  end

  assign btb.stat_branch_o  = stat_branch_q;
  assign btb.stat_mispred_o = stat_mispred_q;

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised branch prediction unit for the next-generation pipelined CPU. It is looked up with the fetch PC in IF and returns a predicted next PC in the same cycle. It is trained by the branch-resolution stage (EX/MEM) through an update port, which also flags mispredictions to the hazard unit. It replaces "always predict not-taken, flush on resolve" with a tagged target table plus a table of 2-bit saturating counters (the pattern table), and keeps saturating statistics counters.

## Interface
Parameters:
- ENTRIES, 16, number of target-table and pattern-table entries; power of two, ≥ 2; IDX_W = log2(ENTRIES).
- ADDR_W, 32, PC width.
- GHR_W, 4, global history length; ≤ IDX_W; used only with the gshare option.
- STAT_W, 16, statistics counter width.

Ports (one clock; reset is asynchronous and active-low):
- clk_i, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- flush_i, input, 1, invalidate all target-table entries.
- lookup_pc_i, input, ADDR_W, fetch PC.
- pred_hit_o, output, 1, target-table hit for lookup_pc_i.
- pred_taken_o, output, 1, predicted taken.
- pred_target_o, output, ADDR_W, predicted next PC.
- pred_ghr_o, output, GHR_W, history used for this lookup; the pipeline carries it to the update port.
- upd_valid_i, input, 1, a branch resolved this cycle.
- upd_pc_i, input, ADDR_W, PC of the resolved branch.
- upd_taken_i, input, 1, actual direction.
- upd_target_i, input, ADDR_W, actual taken target.
- upd_pred_taken_i, input, 1, direction that was predicted.
- upd_pred_target_i, input, ADDR_W, next PC that was predicted.
- upd_ghr_i, input, GHR_W, history carried with the branch.
- mispredict_o, output, 1, resolved branch was mispredicted.
- stat_branch_o, output, STAT_W, resolved-branch count.
- stat_mispred_o, output, STAT_W, misprediction count.

## Operation
- Index is pc[IDX_W+1:2]. Tag is pc[ADDR_W-1:IDX_W+2].
- Target-table entry holds {valid, tag, target}. The pattern table holds ENTRIES 2-bit counters: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Pattern-table index (phi) equals the PC index. With gshare enabled it is the hashed index (see Configuration).
- Lookup is combinational:
  - pred_hit_o = valid && tag match.
  - pred_taken_o = pred_hit_o && counter[1].
  - pred_target_o = pred_taken_o ? stored target : lookup_pc_i + 4, modulo 2^ADDR_W.
- Update, on the clock edge when upd_valid_i is high:
  - The pattern counter at phi(upd_pc_i, upd_ghr_i) saturating-increments if taken and decrements if not taken.
  - If taken, the target entry at the PC index is written {1, tag, upd_target_i}. This allocates or replaces on tag miss and refreshes on hit.
  - If not taken, the target entry is unchanged.
- mispredict_o is combinational: upd_valid_i && ((upd_taken_i != upd_pred_taken_i) || (upd_taken_i && upd_target_i != upd_pred_target_i)).
  - A not-taken branch that was predicted not-taken is correct regardless of the target inputs.
- Statistics: stat_branch_o increments on every upd_valid_i. stat_mispred_o increments on every mispredict_o. Both saturate at all-ones and never wrap.
- flush_i clears every valid bit on the next edge. Pattern counters, history and statistics are untouched.
- flush_i and upd_valid_i in the same cycle: flush wins for valid bits, so no allocation occurs. The counter update and statistics still occur.

## Timing
- Lookup latency 0 cycles. Update takes effect at the edge; it is visible to a lookup in the following cycle.
- Lookup and update to the same index in the same cycle: the lookup returns pre-update contents.
- mispredict_o is valid in the same cycle as upd_valid_i, with no pipelining.
- Reset (asynchronous, at any time including mid-update) sets:
  - all valid bits = 0, all counters = 01, history = 0, statistics = 0;
  - outputs: pred_hit_o = 0, pred_taken_o = 0, pred_target_o = lookup_pc_i + 4, pred_ghr_o = 0, mispredict_o as defined by its inputs.
- No internal state machine. The state is the tables, the history register and the counters.

## Configuration
- BTB_GSHARE_EN defined:
  - phi = pc index XOR {zero-extend(ghr)} into the low GHR_W bits. Lookup uses the current history; update uses upd_ghr_i.
  - The history register shifts left by one and inserts upd_taken_i at bit 0 on each upd_valid_i. It is updated non-speculatively at resolution.
  - pred_ghr_o = history register.
- BTB_GSHARE_EN undefined:
  - phi = pc index. upd_ghr_i is ignored. pred_ghr_o = 0. No history register is built.

## Structure
- Shared package btb_pkg holds:
  - counter encoding constants (CNT_SNT, CNT_WNT, CNT_WT, CNT_ST) and reset value CNT_WNT;
  - the target-entry struct type.
- One sub-module, btb_pht, holds the pattern-table array with one combinational read port, one write port and saturating update logic.

## Test plan
- Reset, then look up 0x0000_0040 -> hit=0, taken=0, target=0x0000_0044.
- Update pc=0x40, taken=1, target=0x100, predicted NT -> mispredict_o=1. Next-cycle lookup 0x40 -> hit=1, counter 10, taken=1, target=0x100. Statistics read 1/1.
- Two not-taken updates at 0x40 after the step above -> counter 00, lookup taken=0, target=0x44, hit still 1. Two further not-taken updates keep the counter at 00, with no underflow.
- Aliasing: ENTRIES=16, allocate 0x40 then a taken update at 0x80 (same index, different tag) -> lookup 0x40 misses and lookup 0x80 hits with the new target. flush_i together with an update -> next-cycle lookup misses.
- STAT_W=4: 20 mispredicted updates -> both statistics read 0xF.
- Gshare enabled, GHR_W=4: taken updates at 0x40 with upd_ghr_i=0 then 3 -> counters at phi 0 and phi 3 are trained independently. pred_ghr_o tracks the shifted history.
